// File: rtl/pipe_pkg.sv
// Shared widths, NOP control word and skid FSM state encoding for the pipeline stage registers.
package pipe_pkg;
  localparam int CTRL_W = 32;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
endpackage

// File: rtl/pipe_skid_buf.sv
// Payload-agnostic main register plus one skid slot; ready is registered so it never depends on drain.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         accept,
  input  logic         drain,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         ready,
  output logic [1:0]   count
);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] main_p1;
  logic [W-1:0] skid_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_nxt = ST_TWO;
        else if (drain && !accept) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (drain) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // Stage boundary: main register (visible output) and FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ready   <= 1'b1;
      main_p1 <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt != ST_TWO);
      if (!flush) begin
        if (state == ST_EMPTY && accept)            main_p1 <= in_data;
        else if (state == ST_ONE && accept && drain) main_p1 <= in_data;
        else if (state == ST_TWO && drain)           main_p1 <= skid_p1;
      end
    end
  end

  // Stage boundary: skid slot catches the item accepted while the output stalls
  always_ff @(posedge clk) begin
    if (!flush && state == ST_ONE && accept && !drain) skid_p1 <= in_data;
  end

  assign out_data  = main_p1;
  assign out_valid = (state != ST_EMPTY);
  assign count     = state;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall, flush and backpressure.
// Define SKID_BUFFER_EN to add a skid slot and break the Out_Ready -> In_Ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = pipe_pkg::CTRL_W,
  parameter int WORD_W    = pipe_pkg::WORD_W,
  parameter int NUM_WORDS = 3,
  parameter int REG_W     = pipe_pkg::REG_W,
  parameter int NUM_REGS  = 3
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [CTRL_W-1:0]           In_Ctrl,
  input  logic [NUM_WORDS*WORD_W-1:0] In_Words,
  input  logic [NUM_REGS*REG_W-1:0]   In_Regs,
  input  logic                        Stall,
  input  logic                        Flush,
  output logic                        Out_Valid,
  input  logic                        Out_Ready,
  output logic [CTRL_W-1:0]           Out_Ctrl,
  output logic [NUM_WORDS*WORD_W-1:0] Out_Words,
  output logic [NUM_REGS*REG_W-1:0]   Out_Regs,
  output logic [1:0]                  Out_Count
);

  localparam int PAY_W = CTRL_W + NUM_WORDS*WORD_W + NUM_REGS*REG_W;

  logic [PAY_W-1:0] pay_p0;
  logic [PAY_W-1:0] pay_p1;
  logic             vld_p1;
  logic             accept;
  logic             drain;

  assign pay_p0 = {In_Ctrl, In_Words, In_Regs};
  assign accept = In_Valid & In_Ready;
  assign drain  = vld_p1 & Out_Ready;

`ifdef SKID_BUFFER_EN
  logic       skid_ready;
  logic [1:0] skid_count;

  assign In_Ready = ~Reset & (Flush | (~Stall & skid_ready));

  pipe_skid_buf #(.W(PAY_W)) u_skid (
    .clk      (Clock),
    .rst      (Reset),
    .flush    (Flush),
    .accept   (accept),
    .drain    (drain),
    .in_data  (pay_p0),
    .out_data (pay_p1),
    .out_valid(vld_p1),
    .ready    (skid_ready),
    .count    (skid_count)
  );

  assign Out_Count = skid_count;
`else
  assign In_Ready = ~Reset & (Flush | (~Stall & (~vld_p1 | Out_Ready)));

  // Stage boundary: single output register; flush keeps the stale data words
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
      pay_p1 <= '0;
    end else if (Flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      pay_p1 <= pay_p0;
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  assign Out_Count = {1'b0, vld_p1};
`endif

  // An empty stage must look like a NOP to the decoder downstream.
  assign Out_Valid = vld_p1;
  assign Out_Ctrl  = vld_p1 ? pay_p1[PAY_W-1 -: CTRL_W] : CTRL_W'(CTRL_NOP);
  assign Out_Words = pay_p1[NUM_REGS*REG_W +: NUM_WORDS*WORD_W];
  assign Out_Regs  = pay_p1[NUM_REGS*REG_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model compared every cycle, plus directed literal checks.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [95:0] words;
    logic [14:0] regs;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ctrl;
  logic [95:0] in_words;
  logic [14:0] in_regs;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ctrl;
  logic [95:0] out_words;
  logic [14:0] out_regs;
  logic [1:0]  out_count;

  int checks   = 0;
  int failures = 0;

  item_t mq[$];
  item_t shown;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .Clock    (clk),
    .Reset    (rst),
    .In_Valid (in_valid),
    .In_Ready (in_ready),
    .In_Ctrl  (in_ctrl),
    .In_Words (in_words),
    .In_Regs  (in_regs),
    .Stall    (stall),
    .Flush    (flush),
    .Out_Valid(out_valid),
    .Out_Ready(out_ready),
    .Out_Ctrl (out_ctrl),
    .Out_Words(out_words),
    .Out_Regs (out_regs),
    .Out_Count(out_count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int capacity();
`ifdef SKID_BUFFER_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  // Ready as seen from the stage's occupancy and the current control inputs.
  function automatic logic exp_ready();
    if (rst) return 1'b0;
    if (flush) return 1'b1;
    if (stall) return 1'b0;
    if (capacity() == 2) return (mq.size() < 2);
    return (mq.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      shown = '0;
    end else begin
      logic  acc;
      logic  drn;
      item_t it;
      acc = in_valid && exp_ready();
      drn = (mq.size() > 0) && out_ready;
      it.ctrl  = in_ctrl;
      it.words = in_words;
      it.regs  = in_regs;
      if (flush) begin
        mq.delete();
      end else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(it);
        if (mq.size() > 0) shown = mq[0];
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ec;
    ec = (mq.size() > 0) ? mq[0].ctrl : 32'd0;
    check("in_ready",  in_ready,  exp_ready());
    check("out_valid", out_valid, mq.size() > 0);
    check("out_ctrl",  out_ctrl,  ec);
    check("out_count", out_count, mq.size());
    check("out_words", out_words, shown.words);
    check("out_regs",  out_regs,  shown.regs);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_words = {c + 32'd2, c + 32'd1, c};
    in_regs  = {c[4:0] ^ 5'h1f, c[4:0] + 5'd1, c[4:0]};
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_words = '0; in_regs = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // reset in the middle of traffic
    out_ready = 1'b1;
    drive(1'b1, 32'h55); step();
    drive(1'b1, 32'h56); step();
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ctrl",  out_ctrl,  32'h0);
    check("rst_out_words", out_words, 96'h0);
    check("rst_out_regs",  out_regs,  15'h0);
    check("rst_out_count", out_count, 2'd0);
    check("rst_in_ready",  in_ready,  1'b0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_ctrl = 32'h1F;
    in_words = {32'd3, 32'd2, 32'd1};
    in_regs  = {5'd3, 5'd2, 5'd1};
    step();
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_ctrl",  out_ctrl,  32'h1F);
    check("t1_out_words", out_words, {32'd3, 32'd2, 32'd1});
    check("t1_out_regs",  out_regs,  {5'd3, 5'd2, 5'd1});

    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(100 + i));
      step();
      check("t2_out_ctrl",  out_ctrl,  32'(100 + i));
      check("t2_out_count", out_count, 2'd1);
    end

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'd200);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_held_ctrl", out_ctrl, 32'd107);
      if (k == 0) check("t3_count", out_count, 2'(capacity()));
    end
    check("t3_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("t3_next_ctrl", out_ctrl, 32'd200);
    in_valid = 1'b0;
    step();

    // stall inserts a bubble, upstream item waits
    drive(1'b1, 32'd300); step();
    check("t4_ctrl_300", out_ctrl, 32'd300);
    stall = 1'b1;
    drive(1'b1, 32'd301); step();
    check("t4_bubble_valid", out_valid, 1'b0);
    check("t4_bubble_ctrl",  out_ctrl,  32'd0);
    stall = 1'b0; step();
    check("t4_ctrl_301", out_ctrl, 32'd301);
    in_valid = 1'b0; step();

    // flush with a full stage
    out_ready = 1'b0;
    drive(1'b1, 32'd400); step();
    drive(1'b1, 32'd401); step();
    check("t5_full_count", out_count, 2'(capacity()));
    flush = 1'b1;
    drive(1'b1, 32'd402); step();
    check("t5_flush_valid", out_valid, 1'b0);
    check("t5_flush_ctrl",  out_ctrl,  32'd0);
    check("t5_flush_count", out_count, 2'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    check("t5_no_ghost", out_valid, 1'b0);

    // flush beats stall
    out_ready = 1'b0;
    drive(1'b1, 32'd500); step();
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 32'd501);
    #1;
    check("t6_in_ready", in_ready, 1'b1);
    step();
    check("t6_valid", out_valid, 1'b0);
    check("t6_count", out_count, 2'd0);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();

    // mixed traffic with intermittent backpressure
    for (int i = 0; i < 12; i++) begin
      drive((i % 3) != 2, 32'(600 + i));
      out_ready = ((i % 4) != 3);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
